sid_pot: RTL
============

SID_POT -- requirements
Module: sid_pot

Interface
REQ-001 SHALL expose parameter SYNC_STAGES, default 2, meaning comparator synchronizer depth in clk flops (legal 2..3).
REQ-002 SHALL expose parameter DISCHARGE_TICKS, default 256, meaning phi2 ticks per discharge phase.
REQ-003 SHALL expose port clk  input  1  system clock; the block has one clock; all logic on rising edge.
REQ-004 SHALL expose port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL expose port phi2_en  input  1  one-clk-wide enable, one per 6510 phi2 cycle (about 1 MHz).
REQ-006 SHALL expose port pot_comp_x  input  1  asynchronous comparator, 1 = POTX pin voltage above threshold.
REQ-007 SHALL expose port pot_comp_y  input  1  asynchronous comparator for POTY, same encoding.
REQ-008 SHALL expose port pot_discharge  output  1  1 = drive both pot pins to ground.
REQ-009 SHALL expose port potx  output  8  last completed POTX conversion (register $19).
REQ-010 SHALL expose port poty  output  8  last completed POTY conversion (register $1A).
REQ-011 SHALL expose port conv_done  output  1  one-clk pulse when potx/poty update.

Function
REQ-012 SHALL synchronize each comparator through SYNC_STAGES flops clocked every clk, independent of phi2_en.
REQ-013 SHALL run a two-state FSM, DISCHARGE and CHARGE, advancing only on clk edges with phi2_en=1.
REQ-014 SHALL hold all state unchanged on edges with phi2_en=0, except the synchronizers.
REQ-015 SHALL assert pot_discharge=1 throughout DISCHARGE and 0 throughout CHARGE, registered.
REQ-016 SHALL remain in DISCHARGE for exactly DISCHARGE_TICKS phi2 ticks using an 8-bit tick counter, then enter CHARGE with counter=0.
REQ-017 SHALL, in CHARGE, increment the 8-bit counter on every phi2 tick from 0 to 255; on the tick at counter=255, return to DISCHARGE with counter=0; full period is 512 ticks.
REQ-018 SHALL, per channel in CHARGE, latch the counter value into a capture register on the first phi2 tick where the synchronized comparator is 1, and set that channel's captured flag.
REQ-019 SHALL ignore later comparator activity, including deassertion, once the captured flag is set, until the next CHARGE.
REQ-020 SHALL capture 0 if the synchronized comparator is already 1 on the first CHARGE tick.
REQ-021 SHALL use 255 for a channel that never crosses, including a crossing first seen on the counter=255 tick, since it yields the same value.
REQ-022 SHALL ignore comparators during DISCHARGE and clear both captured flags on DISCHARGE-to-CHARGE entry.
REQ-023 SHALL, on the counter=255 CHARGE tick, load potx/poty from captures (or 255 per REQ-021) and pulse conv_done on the following clk; latency is crossing tick to output <= 256 ticks.
REQ-024 SHALL update potx and poty atomically on the same clk edge; there is no partial update.
REQ-025 SHALL use counter arithmetic that is 8-bit unsigned with no saturation logic beyond REQ-021.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set FSM=DISCHARGE, counter=0, captures=0, flags=0, synchronizers=0, pot_discharge=1, potx=0, poty=0, conv_done=0.
REQ-027 SHALL let rst override phi2_en; reset mid-CHARGE abandons the conversion and leaves outputs at 0 until the first full conversion 512 ticks later.

Structure
REQ-028 SHALL place the FSM state typedef (DISCHARGE, CHARGE) and the 8-bit count width constant in package sid_pot_pkg.
REQ-029 SHALL implement per-axis synchronizer, flag and capture as sub-module sid_pot_channel, instantiated twice.
REQ-030 SHALL stay within 120-400 lines of RTL total, with no latches and no derived clocks.

Verification
REQ-031 SHALL verify reset release with phi2_en every 4 clk: pot_discharge=1 for 256 ticks, then 0 for 256, then 1 again; potx=poty=0 until first conv_done.
REQ-032 SHALL verify that comp_x rising 100 ticks into CHARGE (after sync) and comp_y never rising gives potx=100 and poty=255 at conv_done.
REQ-033 SHALL verify that comparators held high from reset give potx=poty=0, and that high pulses during DISCHARGE do not alter captures.
REQ-034 SHALL verify that comp_x rising at tick 40, falling at 41 and rising again at 90 gives potx=40.
REQ-035 SHALL verify that rst asserted at CHARGE tick 128 gives all outputs at reset values next clk and no conv_done until 512 ticks after release.
REQ-036 SHALL verify that phi2_en held low for 1000 clk mid-CHARGE freezes counter and outputs, and resuming yields the correct count with no skipped tick.

Source files
------------

// File: rtl/sid_pot_pkg.sv
// sid_pot_pkg: shared types and constants for the SID paddle (POT) converter.
//   CNT_W       : width of the phi2 tick counter and of the conversion results
//   pot_state_t : converter phase, DISCHARGE (pins grounded) or CHARGE (timing)
package sid_pot_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_DISCHARGE = 1'b0,
    ST_CHARGE    = 1'b1
  } pot_state_t;

endpackage

// File: rtl/sid_pot_channel.sv
// sid_pot_channel: one POT axis -- comparator synchronizer, captured flag and
// capture register.
//   clk, rst   : system clock, synchronous active-high reset
//   i_comp     : asynchronous comparator (1 = pin above threshold)
//   i_tick     : phi2 enable; capture logic only moves on these edges
//   i_charge   : converter is in CHARGE
//   i_enter    : this tick is the DISCHARGE-to-CHARGE transition
//   i_cnt      : current tick counter
//   o_value    : capture if a crossing was seen, otherwise all ones
module sid_pot_channel
  import sid_pot_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_comp,
  input  logic             i_tick,
  input  logic             i_charge,
  input  logic             i_enter,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] o_value
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_flag;
  logic [CNT_W-1:0]       r_cap;
  logic                   w_sync;

  // Synchronizer runs every clk, regardless of phi2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_comp};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= 1'b0;
      r_cap  <= '0;
    end else if (i_tick) begin
      if (i_enter) begin
        r_flag <= 1'b0;
      end else if (i_charge && !r_flag && w_sync) begin
        r_cap  <= i_cnt;
        r_flag <= 1'b1;
      end
    end
  end

  // A crossing first seen on the last CHARGE tick would capture 255 anyway,
  // so "no capture" and "captured at 255" both resolve to all ones here.
  assign o_value = r_flag ? r_cap : '1;

endmodule

// File: rtl/sid_pot.sv
// sid_pot: SID paddle converter. Alternates a DISCHARGE phase (pins grounded)
// with a 256-tick CHARGE phase in which each axis records the tick at which
// its comparator first goes high.
//   clk, rst      : system clock, synchronous active-high reset
//   phi2_en       : one-clk enable per 6510 phi2 cycle
//   pot_comp_x/y  : asynchronous comparators for POTX / POTY
//   pot_discharge : 1 = ground both pot pins
//   potx, poty    : last completed conversions ($19 / $1A)
//   conv_done     : one-clk pulse after potx/poty update
module sid_pot
  import sid_pot_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DISCHARGE_TICKS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phi2_en,
  input  logic             pot_comp_x,
  input  logic             pot_comp_y,
  output logic             pot_discharge,
  output logic [CNT_W-1:0] potx,
  output logic [CNT_W-1:0] poty,
  output logic             conv_done
);

  localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_TICKS - 1);

  pot_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_charge;
  logic             w_enter;
  logic [CNT_W-1:0] w_val_x;
  logic [CNT_W-1:0] w_val_y;

  assign w_charge = (r_state == ST_CHARGE);
  assign w_enter  = (r_state == ST_DISCHARGE) && (r_cnt == DIS_LAST);

  sid_pot_channel #(.SYNC_STAGES(SYNC_STAGES)) u_chan_x (
    .clk      (clk),
    .rst      (rst),
    .i_comp   (pot_comp_x),
    .i_tick   (phi2_en),
    .i_charge (w_charge),
    .i_enter  (w_enter),
    .i_cnt    (r_cnt),
    .o_value  (w_val_x)
  );

  sid_pot_channel #(.SYNC_STAGES(SYNC_STAGES)) u_chan_y (
    .clk      (clk),
    .rst      (rst),
    .i_comp   (pot_comp_y),
    .i_tick   (phi2_en),
    .i_charge (w_charge),
    .i_enter  (w_enter),
    .i_cnt    (r_cnt),
    .o_value  (w_val_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_DISCHARGE;
      r_cnt         <= '0;
      pot_discharge <= 1'b1;
      potx          <= '0;
      poty          <= '0;
      conv_done     <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      if (phi2_en) begin
        unique case (r_state)
          ST_DISCHARGE: begin
            if (r_cnt == DIS_LAST) begin
              r_state       <= ST_CHARGE;
              r_cnt         <= '0;
              pot_discharge <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_CHARGE: begin
            if (r_cnt == '1) begin
              r_state       <= ST_DISCHARGE;
              r_cnt         <= '0;
              pot_discharge <= 1'b1;
              potx          <= w_val_x;
              poty          <= w_val_y;
              conv_done     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_DISCHARGE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
